// File: rtl/vx_tex_sampler_if.sv
// Request/response bundle between the texture memory stage, the sampler and the response path.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high;
// the source holds valid and its payload stable until that edge, and ready may depend combinationally on the sink's state.
interface vx_tex_sampler_if #(
  parameter int NUM_LANES = 1,
  parameter int REQ_INFOW = 1
);
  logic                             req_valid;
  logic [NUM_LANES-1:0]             req_mask;
  logic [2:0]                       req_format;
  logic                             req_filter;
  logic [NUM_LANES-1:0][7:0]        req_blend_u;
  logic [NUM_LANES-1:0][7:0]        req_blend_v;
  logic [NUM_LANES-1:0][3:0][31:0]  req_data;
  logic [REQ_INFOW-1:0]             req_info;
  logic                             req_ready;

  logic                             rsp_valid;
  logic [NUM_LANES-1:0]             rsp_mask;
  logic [NUM_LANES-1:0][31:0]       rsp_data;
  logic [REQ_INFOW-1:0]             rsp_info;
  logic                             rsp_ready;

  modport master (
    output req_valid, req_mask, req_format, req_filter, req_blend_u, req_blend_v, req_data, req_info,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_mask, rsp_data, rsp_info
  );

  modport slave (
    input  req_valid, req_mask, req_format, req_filter, req_blend_u, req_blend_v, req_data, req_info,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_mask, rsp_data, rsp_info
  );
endinterface

// File: rtl/vx_tex_sampler.sv
// Texture filter: decode (S0), horizontal lerp (S1), vertical lerp (S2); one global stall enable.
// Optional TEX_SAMPLER_PERF_EN adds the perf_stalls output-backpressure counter.
module vx_tex_sampler #(
  parameter string INSTANCE_ID = "",
  parameter int    NUM_LANES   = 1,
  parameter int    REQ_INFOW   = 1
) (
  input logic             clk,
  input logic             reset,
  vx_tex_sampler_if.slave tex_if
`ifdef TEX_SAMPLER_PERF_EN
  ,
  output logic [31:0]     perf_stalls
`endif
);

  function automatic logic [31:0] decode_texel(input logic [2:0] fmt, input logic [31:0] t);
    logic [31:0] c;
    c = '0;
    case (fmt)
      3'd0:    c = t;
      3'd1:    c = {8'hFF, t[15:11], t[15:13], t[10:5], t[10:9], t[4:0], t[4:2]};
      3'd2:    c = {{8{t[15]}}, t[14:10], t[14:12], t[9:5], t[9:7], t[4:0], t[4:2]};
      3'd3:    c = {t[15:12], t[15:12], t[11:8], t[11:8], t[7:4], t[7:4], t[3:0], t[3:0]};
      3'd4:    c = {t[15:8], {3{t[7:0]}}};
      3'd5:    c = {8'hFF, {3{t[7:0]}}};
      3'd6:    c = {t[7:0], 24'h0};
      default: c = '0;
    endcase
    return c;
  endfunction

  // Worst case a*(256-f)+b*f+128 is 65408, so 17 bits never overflow and the result fits 8 bits.
  function automatic logic [7:0] lerp8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    logic [16:0] s;
    s = 17'(a) * (17'd256 - 17'(f)) + 17'(b) * 17'(f) + 17'd128;
    return 8'(s >> 8);
  endfunction

  function automatic logic [31:0] lerp_rgba(input logic [31:0] a, input logic [31:0] b, input logic [7:0] f);
    logic [31:0] o;
    o = '0;
    for (int ch = 0; ch < 4; ch++) o[ch*8 +: 8] = lerp8(a[ch*8 +: 8], b[ch*8 +: 8], f);
    return o;
  endfunction

  logic                            enable;

  logic                            s0_valid;
  logic [NUM_LANES-1:0]            s0_mask;
  logic [REQ_INFOW-1:0]            s0_info;
  logic [NUM_LANES-1:0][7:0]       s0_bu, s0_bv;
  logic [NUM_LANES-1:0][3:0][31:0] s0_tex;

  logic                            s1_valid;
  logic [NUM_LANES-1:0]            s1_mask;
  logic [REQ_INFOW-1:0]            s1_info;
  logic [NUM_LANES-1:0][7:0]       s1_bv;
  logic [NUM_LANES-1:0][31:0]      s1_t01, s1_t23;

  logic                            s2_valid;
  logic [NUM_LANES-1:0]            s2_mask;
  logic [REQ_INFOW-1:0]            s2_info;
  logic [NUM_LANES-1:0][31:0]      s2_data;

  logic [NUM_LANES-1:0][3:0][31:0] dec_tex;
  logic [NUM_LANES-1:0][7:0]       in_bu, in_bv;
  logic [NUM_LANES-1:0][31:0]      h01, h23, vout;

  assign enable           = ~s2_valid | tex_if.rsp_ready;
  assign tex_if.req_ready = enable;

  // Point sampling forces both fractions to zero, so every lerp returns texel 0 exactly.
  always_comb begin
    dec_tex = '0;
    for (int l = 0; l < NUM_LANES; l++)
      for (int t = 0; t < 4; t++)
        dec_tex[l][t] = decode_texel(tex_if.req_format, tex_if.req_data[l][t]);
    in_bu = tex_if.req_filter ? tex_if.req_blend_u : '0;
    in_bv = tex_if.req_filter ? tex_if.req_blend_v : '0;
  end

  always_comb begin
    h01 = '0;
    h23 = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      h01[l] = lerp_rgba(s0_tex[l][0], s0_tex[l][1], s0_bu[l]);
      h23[l] = lerp_rgba(s0_tex[l][2], s0_tex[l][3], s0_bu[l]);
    end
  end

  always_comb begin
    vout = '0;
    for (int l = 0; l < NUM_LANES; l++)
      vout[l] = s1_mask[l] ? lerp_rgba(s1_t01[l], s1_t23[l], s1_bv[l]) : 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_valid <= 1'b0; s0_mask <= '0; s0_info <= '0; s0_bu <= '0; s0_bv <= '0; s0_tex <= '0;
      s1_valid <= 1'b0; s1_mask <= '0; s1_info <= '0; s1_bv <= '0; s1_t01 <= '0; s1_t23 <= '0;
      s2_valid <= 1'b0; s2_mask <= '0; s2_info <= '0; s2_data <= '0;
    end else if (enable) begin
      s0_valid <= tex_if.req_valid;
      s0_mask  <= tex_if.req_mask;
      s0_info  <= tex_if.req_info;
      s0_bu    <= in_bu;
      s0_bv    <= in_bv;
      s0_tex   <= dec_tex;
      s1_valid <= s0_valid;
      s1_mask  <= s0_mask;
      s1_info  <= s0_info;
      s1_bv    <= s0_bv;
      s1_t01   <= h01;
      s1_t23   <= h23;
      s2_valid <= s1_valid;
      s2_mask  <= s1_mask;
      s2_info  <= s1_info;
      s2_data  <= vout;
    end
  end

  assign tex_if.rsp_valid = s2_valid;
  assign tex_if.rsp_mask  = s2_mask;
  assign tex_if.rsp_info  = s2_info;
  assign tex_if.rsp_data  = s2_data;

`ifdef TEX_SAMPLER_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            stall_cnt <= '0;
    else if (s2_valid && !tex_if.rsp_ready) stall_cnt <= stall_cnt + 32'd1;
  end

  assign perf_stalls = stall_cnt;
`endif

endmodule

// File: tb/tb_vx_tex_sampler.sv
// Randomized and directed bench for vx_tex_sampler against a behavioural colour model.
module tb_vx_tex_sampler;
  localparam int NL = 4;
  localparam int IW = 8;
  localparam int W  = NL + IW + NL * 32;

  typedef struct {
    logic [2:0]                fmt;
    logic                      filt;
    logic [NL-1:0]             mask;
    logic [NL-1:0][7:0]        bu;
    logic [NL-1:0][7:0]        bv;
    logic [NL-1:0][3:0][31:0]  data;
    logic [IW-1:0]             info;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vx_tex_sampler_if #(.NUM_LANES(NL), .REQ_INFOW(IW)) sif ();
`ifdef TEX_SAMPLER_PERF_EN
  logic [31:0] perf_stalls;
`endif

  vx_tex_sampler #(.INSTANCE_ID("tb"), .NUM_LANES(NL), .REQ_INFOW(IW)) dut (
    .clk    (clk),
    .reset  (reset),
    .tex_if (sif.slave)
`ifdef TEX_SAMPLER_PERF_EN
    ,
    .perf_stalls (perf_stalls)
`endif
  );

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  int perf_model = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int w5(input int x); return x * 8 + x / 4; endfunction
  function automatic int w6(input int x); return x * 4 + x / 16; endfunction
  function automatic int lerp_m(input int a, input int b, input int f);
    return (a * (256 - f) + b * f + 128) / 256;
  endfunction

  function automatic logic [31:0] model_texel(input logic [2:0] fmt, input logic [31:0] t);
    int v, lo, hi, a, r, g, b;
    v  = int'(t[15:0]);
    lo = v % 256;
    hi = v / 256;
    a = 0; r = 0; g = 0; b = 0;
    case (fmt)
      3'd0: begin a = int'(t >> 24); r = int'(t >> 16) % 256; g = hi; b = lo; end
      3'd1: begin a = 255; r = w5(v / 2048); g = w6((v / 32) % 64); b = w5(v % 32); end
      3'd2: begin a = (v / 32768) * 255; r = w5((v / 1024) % 32); g = w5((v / 32) % 32); b = w5(v % 32); end
      3'd3: begin a = (v / 4096) * 17; r = ((v / 256) % 16) * 17; g = ((v / 16) % 16) * 17; b = (v % 16) * 17; end
      3'd4: begin a = hi; r = lo; g = lo; b = lo; end
      3'd5: begin a = 255; r = lo; g = lo; b = lo; end
      3'd6: begin a = lo; end
      default: ;
    endcase
    return 32'(longint'(a) * 16777216 + longint'(r) * 65536 + longint'(g) * 256 + longint'(b));
  endfunction

  function automatic int chan(input logic [31:0] c, input int ch);
    return int'((longint'(c) / (longint'(1) << (8 * ch))) % 256);
  endfunction

  function automatic logic [W-1:0] model_rsp(input req_t r);
    logic [NL-1:0][31:0] d;
    logic [31:0] tx [4];
    longint acc;
    int t01, t23;
    d = '0;
    for (int l = 0; l < NL; l++) begin
      if (r.mask[l]) begin
        for (int k = 0; k < 4; k++) tx[k] = model_texel(r.fmt, r.data[l][k]);
        if (!r.filt) d[l] = tx[0];
        else begin
          acc = 0;
          for (int ch = 0; ch < 4; ch++) begin
            t01 = lerp_m(chan(tx[0], ch), chan(tx[1], ch), int'(r.bu[l]));
            t23 = lerp_m(chan(tx[2], ch), chan(tx[3], ch), int'(r.bu[l]));
            acc = acc + (longint'(lerp_m(t01, t23, int'(r.bv[l]))) << (8 * ch));
          end
          d[l] = 32'(acc);
        end
      end
    end
    return {r.mask, r.info, d};
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] rand_frac();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.fmt  = 3'($urandom_range(0, 7));
    r.filt = 1'($urandom_range(0, 1));
    r.mask = NL'($urandom);
    r.info = IW'($urandom);
    for (int l = 0; l < NL; l++) begin
      r.bu[l] = rand_frac();
      r.bv[l] = rand_frac();
      for (int k = 0; k < 4; k++) r.data[l][k] = $urandom;
    end
    return r;
  endfunction

  function automatic req_t mk(input logic [2:0] fmt, input logic filt, input logic [NL-1:0] mask,
                              input logic [7:0] u, input logic [7:0] v,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3, input logic [IW-1:0] info);
    req_t r;
    r = rand_req();
    r.fmt = fmt; r.filt = filt; r.mask = mask; r.info = info;
    r.bu[0] = u; r.bv[0] = v;
    r.data[0][0] = d0; r.data[0][1] = d1; r.data[0][2] = d2; r.data[0][3] = d3;
    return r;
  endfunction

  task automatic send(input req_t r);
    int n = 0;
    sif.req_format  = r.fmt;
    sif.req_filter  = r.filt;
    sif.req_mask    = r.mask;
    sif.req_blend_u = r.bu;
    sif.req_blend_v = r.bv;
    sif.req_data    = r.data;
    sif.req_info    = r.info;
    sif.req_valid   = 1'b1;
    @(negedge clk);
    while (!sif.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sif.req_ready) begin
      check("send_timeout", W'(sif.req_ready), W'(1));
      sif.req_valid = 1'b0;
      return;
    end
    exp_q.push_back(model_rsp(r));
    @(posedge clk);
    acc_cnt++;
    #1;
    sif.req_valid = 1'b0;
  endtask

  task automatic idle();
    sif.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!sif.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = sif.rsp_valid;
    if (!ok) check({tag, "_timeout"}, W'(sif.rsp_valid), W'(1));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, W'(exp_q.size()), W'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input req_t r, input logic [31:0] exp_lane0);
    bit ok;
    send(r);
    idle();
    wait_rsp(tag, ok);
    if (ok) check(tag, W'(sif.rsp_data[0]), W'(exp_lane0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sif.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", W'(sif.rsp_valid), W'(0));
    check("rst_rsp_mask",  W'(sif.rsp_mask),  W'(0));
    check("rst_rsp_data",  W'(sif.rsp_data),  W'(0));
    check("rst_rsp_info",  W'(sif.rsp_info),  W'(0));
    check("rst_req_ready", W'(sif.req_ready), W'(1));
`ifdef TEX_SAMPLER_PERF_EN
    check("rst_perf", W'(perf_stalls), W'(0));
`endif
    exp_q.delete();
    perf_model = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (sif.rsp_valid && !sif.rsp_ready) perf_model++;
      if (sif.rsp_valid && sif.rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) check("rsp_unexpected", W'(sif.rsp_valid), W'(0));
        else begin
          mon_exp = exp_q.pop_front();
          check("rsp", {sif.rsp_mask, sif.rsp_info, sif.rsp_data}, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    req_t r;
    bit ok;
    int acc0, rsp0;
    bit done;
    sif.req_valid = 1'b0; sif.req_mask = '0; sif.req_format = '0; sif.req_filter = 1'b0;
    sif.req_blend_u = '0; sif.req_blend_v = '0; sif.req_data = '0; sif.req_info = '0;
    sif.rsp_ready = 1'b1;
    do_reset();

    // L8 point sample, latency and tag
    r = mk(3'd5, 1'b0, 4'b0001, 8'h33, 8'h44, 32'h0000005A, $urandom, $urandom, $urandom, 8'hA5);
    send(r);
    idle();
    @(negedge clk); check("lat_1", W'(sif.rsp_valid), W'(0));
    @(negedge clk); check("lat_2", W'(sif.rsp_valid), W'(0));
    @(negedge clk); check("lat_3", W'(sif.rsp_valid), W'(1));
    check("l8_data", W'(sif.rsp_data[0]), W'(32'hFF5A5A5A));
    check("l8_info", W'(sif.rsp_info), W'(8'hA5));
    @(posedge clk); #1;

    directed("bil_argb", mk(3'd0, 1'b1, 4'b0001, 8'h80, 8'h00, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 8'h11), 32'h80808080);
    directed("pt_565",   mk(3'd1, 1'b0, 4'b0001, 8'h77, 8'h99, 32'h0000F800, 32'h1, 32'h2, 32'h3, 8'h12), 32'hFFFF0000);
    directed("pt_1555",  mk(3'd2, 1'b0, 4'b0001, 8'h10, 8'h20, 32'h0000001F, 32'h1, 32'h2, 32'h3, 8'h13), 32'h000000FF);
    directed("pt_4444",  mk(3'd3, 1'b0, 4'b0001, 8'h10, 8'h20, 32'h00001234, 32'h1, 32'h2, 32'h3, 8'h14), 32'h11223344);
    directed("bil_v_a8", mk(3'd6, 1'b1, 4'b0001, 8'h00, 8'h80, 32'h0, 32'h0, 32'hFF, 32'hFF, 8'h15), 32'h80000000);
    directed("pt_resv",  mk(3'd7, 1'b0, 4'b0001, 8'h00, 8'h00, 32'hFFFFFFFF, 32'h1, 32'h2, 32'h3, 8'h16), 32'h00000000);

    // inactive lanes
    r = mk(3'd0, 1'b0, 4'b0101, 8'h00, 8'h00, 32'hDEADBEEF, 32'h1, 32'h2, 32'h3, 8'h17);
    r.data[1][0] = 32'hFFFFFFFF;
    r.data[3][0] = 32'h12345678;
    send(r);
    idle();
    wait_rsp("mask", ok);
    if (ok) begin
      check("mask_lane1", W'(sif.rsp_data[1]), W'(0));
      check("mask_lane3", W'(sif.rsp_data[3]), W'(0));
      check("mask_lane0", W'(sif.rsp_data[0]), W'(32'hDEADBEEF));
      check("mask_rsp",   W'(sif.rsp_mask), W'(4'b0101));
    end
    @(posedge clk); #1;

    // backpressure: 8 back-to-back, output held off for 5 cycles
    do_reset();
    sif.rsp_ready = 1'b0;
    acc0 = acc_cnt;
    rsp0 = rsp_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_req());
        idle();
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!sif.rsp_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("stall_fill", W'(sif.rsp_valid), W'(1));
        repeat (5) @(posedge clk);
        #1;
        check("stall_accepts", W'(acc_cnt - acc0), W'(3));
        check("stall_req_ready", W'(sif.req_ready), W'(0));
        sif.rsp_ready = 1'b1;
      end
    join
    drain("stall");
    check("stall_rsp_cnt", W'(rsp_cnt - rsp0), W'(8));
`ifdef TEX_SAMPLER_PERF_EN
    check("stall_perf", W'(perf_stalls), W'(5));
`endif

    // reset with two requests in flight
    sif.rsp_ready = 1'b1;
    send(rand_req());
    send(rand_req());
    reset = 1'b0;
    #1;
    check("midrst_valid", W'(sif.rsp_valid), W'(0));
    check("midrst_data",  W'(sif.rsp_data),  W'(0));
    exp_q.delete();
    perf_model = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rsp0 = rsp_cnt;
    repeat (6) @(negedge clk);
    check("midrst_no_ghost", W'(rsp_cnt - rsp0), W'(0));
    check("midrst_idle", W'(sif.rsp_valid), W'(0));
    @(posedge clk); #1;
    send(rand_req());
    idle();
    wait_rsp("midrst_new", ok);
    drain("midrst");
    check("midrst_new_cnt", W'(rsp_cnt - rsp0), W'(1));

    // random traffic with random backpressure
    done = 1'b0;
    rsp0 = rsp_cnt;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            idle();
            @(posedge clk);
            #1;
          end
          send(rand_req());
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          sif.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        sif.rsp_ready = 1'b1;
      end
    join
    drain("rand");
    check("rand_rsp_cnt", W'(rsp_cnt - rsp0), W'(150));
`ifdef TEX_SAMPLER_PERF_EN
    check("rand_perf", W'(perf_stalls), W'(perf_model));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
